// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller: per-stage load/clear enables with backpressure,
// bubble collapse and partial flush that blocks the input for a fixed window.

module pipe_stage_slot (
  input  logic clk,
  input  logic reset,
  input  logic kill,
  input  logic en,
  input  logic src_valid,
  output logic valid
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    valid <= 1'b0;
    else if (kill) valid <= 1'b0;
    else if (en)   valid <= src_valid;
  end
endmodule

module pipe_stage_ctrl #(
  parameter int STAGES       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [STAGES-1:0] en,
  output logic [STAGES-1:0] clr,
  output logic [STAGES-1:0] valid,
  output logic              flushing
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [STAGES-1:0] hold, kill, src_valid;
  logic              rdy, any_flush, blk;

  assign any_flush = |flush_req;

  // Backpressure walks from the output toward stage 0; an empty stage absorbs it.
  always_comb begin
    hold      = '0;
    kill      = '0;
    src_valid = '0;
    blk       = ~out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hold[i] = stall_req[i] | (valid[i] & blk);
      blk     = hold[i];
      kill[i] = |(flush_req >> i);
    end
    rdy          = (state == RUN) & ~hold[0] & ~any_flush;
    src_valid[0] = in_valid & rdy;
    for (int i = 1; i < STAGES; i++)
      src_valid[i] = valid[i-1] & ~hold[i-1];
  end

  assign en        = ~hold;
  assign clr       = reset ? (kill | (en & ~src_valid)) : '1;
  assign in_ready  = reset & rdy;
  assign out_valid = valid[STAGES-1];
  assign flushing  = (state == FLUSH);

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_stage_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .kill      (kill[g]),
      .en        (en[g]),
      .src_valid (src_valid[g]),
      .valid     (valid[g])
    );
  end

  // Any flush request (re)arms the window; leaving FLUSH happens as the count hits zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (any_flush) begin
      state <= FLUSH;
      cnt   <= CW'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      if (cnt <= CW'(1)) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule
